// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: walks the instruction register from a start pointer,
// issues valid entries over a valid/ready handshake and counts skipped ones.
package instr_fetch_pkg;
    localparam int MEMORY_SIZE = 32;

    typedef logic [4:0] pointer4_t;

    typedef enum logic [2:0] {
        ZERO,
        ADD,
        SUB,
        AND_OP,
        OR_OP,
        LOAD,
        STORE,
        BRANCH
    } opcode_t;

    typedef struct packed {
        opcode_t     opc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [13:0] imm;
    } instruction_t;
endpackage

module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = MEMORY_SIZE,
    parameter int PTR_W = 5,
    parameter int CNT_W = 6
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               start_i,
    input  logic [PTR_W-1:0]   start_ptr_i,
    input  logic [CNT_W-1:0]   count_i,
    input  logic               abort_i,
    output logic [PTR_W-1:0]   read_pointer_o,
    input  instruction_t       instruction_word_i,
    input  logic               valid_i,
    output instruction_t       out_instr_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [CNT_W-1:0]   issued_cnt_o,
    output logic [CNT_W-1:0]   skip_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   readPtr_q, readPtr_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    instruction_t       outInstr_q, outInstr_d;
    logic               outValid_q, outValid_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   issued_q, issued_d;
    logic [CNT_W-1:0]   skip_q, skip_d;
    logic               canLoad;
    logic [CNT_W-1:0]   countClip;
    logic [PTR_W-1:0]   ptrNext;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign canLoad   = !outValid_q || out_ready_i;
    assign countClip = (count_i > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : count_i;
    assign ptrNext   = (readPtr_q == PTR_W'(DEPTH - 1)) ? '0 : readPtr_q + 1'b1;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            readPtr_q   <= '0;
            remaining_q <= '0;
            outInstr_q  <= '{opc: ZERO, default: '0};
            outValid_q  <= 1'b0;
            done_q      <= 1'b0;
            issued_q    <= '0;
            skip_q      <= '0;
        end else begin
            state_q     <= state_d;
            readPtr_q   <= readPtr_d;
            remaining_q <= remaining_d;
            outInstr_q  <= outInstr_d;
            outValid_q  <= outValid_d;
            done_q      <= done_d;
            issued_q    <= issued_d;
            skip_q      <= skip_d;
        end
    end

    // Abort wins over everything; a stalled handshake freezes the whole walk.
    always_comb begin
        state_d     = state_q;
        readPtr_d   = readPtr_q;
        remaining_d = remaining_q;
        outInstr_d  = outInstr_q;
        outValid_d  = outValid_q;
        done_d      = 1'b0;
        issued_d    = issued_q;
        skip_d      = skip_q;

        if (abort_i) begin
            state_d    = IDLE;
            outValid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        readPtr_d   = start_ptr_i;
                        remaining_d = countClip;
                        issued_d    = '0;
                        skip_d      = '0;
                        state_d     = (countClip == '0) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (canLoad) begin
                        if (valid_i) begin
                            outInstr_d = instruction_word_i;
                            outValid_d = 1'b1;
                            issued_d   = satInc(issued_q);
                        end else begin
                            outValid_d = 1'b0;
                            skip_d     = satInc(skip_q);
                        end
                        readPtr_d   = ptrNext;
                        remaining_d = remaining_q - 1'b1;
                        if (remaining_q <= CNT_W'(1)) begin
                            state_d = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (canLoad) begin
                        outValid_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    outValid_d = 1'b0;
                end
            endcase
        end
    end

    assign read_pointer_o = readPtr_q;
    assign out_instr_o    = outInstr_q;
    assign out_valid_o    = outValid_q;
    assign busy_o         = (state_q != IDLE);
    assign done_o         = done_q;
    assign issued_cnt_o   = issued_q;
    assign skip_cnt_o     = skip_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a register-file model feeds the DUT and a
// per-run scoreboard predicts issue order, counters and done timing.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          resetN;
    logic          start;
    logic [4:0]    startPtr;
    logic [5:0]    countIn;
    logic          abort;
    logic [4:0]    readPointer;
    instruction_t  instructionWord;
    logic          entryValid;
    instruction_t  outInstr;
    logic          outValid;
    logic          outReady;
    logic          busy;
    logic          done;
    logic [5:0]    issuedCnt;
    logic [5:0]    skipCnt;

    instruction_t  mem [DEPTH];
    logic          memValid [DEPTH];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign instructionWord = mem[readPointer];
    assign entryValid      = memValid[readPointer];

    instr_fetch #(.DEPTH(DEPTH), .PTR_W(5), .CNT_W(6)) dut (
        .clk_i              (clk),
        .reset_n_i          (resetN),
        .start_i            (start),
        .start_ptr_i        (startPtr),
        .count_i            (countIn),
        .abort_i            (abort),
        .read_pointer_o     (readPointer),
        .instruction_word_i (instructionWord),
        .valid_i            (entryValid),
        .out_instr_o        (outInstr),
        .out_valid_o        (outValid),
        .out_ready_i        (outReady),
        .busy_o             (busy),
        .done_o             (done),
        .issued_cnt_o       (issuedCnt),
        .skip_cnt_o         (skipCnt)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic randomizeMem();
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]      = instruction_t'($urandom);
            memValid[i] = ($urandom_range(0, 3) != 0);
        end
    endtask

    // readyMode: 0 = always ready, 1 = random ready, 2 = ready low 3 cycles on the second issue
    task automatic applyStimulus(input int ptr, input int cnt, input int readyMode,
                                 input bit pokeStart, input string name);
        instruction_t expQ[$];
        instruction_t prevInstr;
        int n;
        int expSkip = 0;
        int expIssued;
        int c;
        int issueIdx = 0;
        int lowLeft = 0;
        int stalls = 0;
        bit seenDone = 1'b0;
        bit prevStalled = 1'b0;

        n = (cnt > DEPTH) ? DEPTH : cnt;
        for (int i = 0; i < n; i++) begin
            if (memValid[(ptr + i) % DEPTH]) expQ.push_back(mem[(ptr + i) % DEPTH]);
            else expSkip++;
        end
        expIssued = expQ.size();

        startPtr = 5'(ptr);
        countIn  = 6'(cnt);
        outReady = 1'b1;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 1;
        checkOutput({name, " busy after start"}, busy, 1);
        checkOutput({name, " first pointer"}, readPointer, ptr);

        while (!seenDone && c < 400) begin
            case (readyMode)
                0: outReady = 1'b1;
                1: outReady = 1'($urandom_range(0, 1));
                default: begin
                    if (lowLeft == 0 && stalls == 0 && issueIdx == 1 && outValid) lowLeft = 3;
                    if (lowLeft > 0) begin
                        outReady = 1'b0;
                        lowLeft--;
                        stalls++;
                    end else begin
                        outReady = 1'b1;
                    end
                end
            endcase
            start = pokeStart && (c == 3);
            if (pokeStart && c == 3) startPtr = 5'(ptr + 7);

            if (readyMode == 0 && c <= n)
                checkOutput({name, " pointer sequence"}, readPointer, (ptr + c - 1) % DEPTH);
            if (prevStalled)
                checkOutput({name, " held instr stable"}, outInstr, prevInstr);
            if (outValid && outReady) begin
                checkOutput({name, " issue within expected"}, issueIdx < expIssued, 1);
                if (expQ.size() > 0) begin
                    checkOutput({name, " issued instr"}, outInstr, expQ[0]);
                    void'(expQ.pop_front());
                end
                issueIdx++;
            end
            prevStalled = outValid && !outReady;
            prevInstr   = outInstr;

            @(posedge clk); #1;
            start = 1'b0;
            c++;
            if (done) seenDone = 1'b1;
        end

        outReady = 1'b1;
        checkOutput({name, " done seen"}, seenDone, 1);
        if (readyMode != 1)
            checkOutput({name, " done cycle"}, c, 2 + n + ((readyMode == 2) ? 3 : 0));
        checkOutput({name, " busy at done"}, busy, 0);
        checkOutput({name, " out_valid at done"}, outValid, 0);
        checkOutput({name, " issued_cnt"}, issuedCnt, expIssued);
        checkOutput({name, " skip_cnt"}, skipCnt, expSkip);
        checkOutput({name, " all issued"}, issueIdx, expIssued);
        @(posedge clk); #1;
        checkOutput({name, " done single pulse"}, done, 0);
    endtask

    initial begin
        bit anyDone;

        resetN   = 1'b0;
        start    = 1'b0;
        startPtr = '0;
        countIn  = '0;
        abort    = 1'b0;
        outReady = 1'b1;
        randomizeMem();

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset read_pointer", readPointer, 0);
        checkOutput("reset out_valid", outValid, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset issued_cnt", issuedCnt, 0);
        checkOutput("reset skip_cnt", skipCnt, 0);
        checkOutput("reset out_instr", outInstr, 0);
        resetN = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) memValid[i] = 1'b1;
        applyStimulus(0, 4, 0, 1'b0, "basic");

        for (int i = 1; i <= 5; i++) memValid[i] = 1'b1;
        memValid[2] = 1'b0;
        memValid[4] = 1'b0;
        applyStimulus(1, 5, 0, 1'b0, "skip");
        checkOutput("skip fixed skip_cnt", skipCnt, 2);
        checkOutput("skip fixed issued_cnt", issuedCnt, 3);

        memValid[30] = 1'b1;
        memValid[31] = 1'b1;
        memValid[0]  = 1'b1;
        memValid[1]  = 1'b1;
        applyStimulus(30, 4, 0, 1'b0, "wrap");

        for (int i = 8; i <= 12; i++) memValid[i] = 1'b1;
        applyStimulus(8, 5, 2, 1'b0, "backpressure");

        applyStimulus(3, 0, 0, 1'b0, "count0");

        randomizeMem();
        applyStimulus(5, 40, 0, 1'b1, "count40");
        checkOutput("count40 walked", issuedCnt + skipCnt, 32);

        for (int k = 0; k < 6; k++) begin
            randomizeMem();
            applyStimulus($urandom_range(0, 31), $urandom_range(0, 40), 1, 1'b0, "random_ready");
        end
        for (int k = 0; k < 2; k++) begin
            randomizeMem();
            applyStimulus($urandom_range(0, 31), $urandom_range(1, 40), 0, 1'b0, "random_full");
        end

        // Abort after two fetches: counters freeze, no done pulse follows
        for (int i = 0; i < 10; i++) memValid[i] = 1'b1;
        startPtr = 5'd0;
        countIn  = 6'd10;
        outReady = 1'b1;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("abort busy", busy, 0);
        checkOutput("abort out_valid", outValid, 0);
        checkOutput("abort done", done, 0);
        checkOutput("abort issued_cnt kept", issuedCnt, 2);
        anyDone = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) anyDone = 1'b1;
        end
        checkOutput("abort no later done", anyDone, 0);

        // Reset mid-cycle while running: outputs must clear without a clock edge
        startPtr = 5'd0;
        countIn  = 6'd10;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("midreset read_pointer", readPointer, 0);
        checkOutput("midreset out_valid", outValid, 0);
        checkOutput("midreset busy", busy, 0);
        checkOutput("midreset issued_cnt", issuedCnt, 0);
        checkOutput("midreset out_instr", outInstr, 0);
        @(posedge clk); #1;
        resetN = 1'b1;
        @(posedge clk); #1;

        randomizeMem();
        applyStimulus(12, 6, 0, 1'b0, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Reader-side sequencer for the instruction register. On a start command it walks the register from a given pointer for a given number of entries. It drives `read_pointer` and samples the combinational `instruction_word`/`valid` return. Valid entries are issued to the downstream execute stage over a valid/ready handshake, and invalid entries are skipped and counted.

## Interface
Parameters:
- `DEPTH`, default `MEMORY_SIZE` (32): number of instruction register entries.
- `PTR_W`, default 5: pointer width, matching `pointer4_t`.
- `CNT_W`, default 6: width of the count and statistics fields; must hold `DEPTH`.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle run request; sampled only in IDLE.
- `start_ptr`  in  PTR_W  first entry to read.
- `count`  in  CNT_W  number of entries to walk; values above DEPTH are treated as DEPTH.
- `abort`  in  1  terminates the current run.
- `read_pointer`  out  PTR_W  registered pointer to the instruction register.
- `instruction_word`  in  instruction_t  entry at `read_pointer`, returned combinationally.
- `valid`  in  1  entry-valid flag at `read_pointer`.
- `out_instr`  out  instruction_t  issued instruction.
- `out_valid`  out  1  `out_instr` holds an unaccepted instruction.
- `out_ready`  in  1  downstream accepts when this and `out_valid` are both high.
- `busy`  out  1  run in progress (RUN or DRAIN).
- `done`  out  1  one-cycle pulse when a run completes normally.
- `issued_cnt`  out  CNT_W  entries issued in the current or last run.
- `skip_cnt`  out  CNT_W  invalid entries skipped in the current or last run.

## Operation
- The state machine has three states: IDLE, RUN and DRAIN.
- Reset values:
  - State is IDLE.
  - `read_pointer`, `out_valid`, `busy`, `done`, `issued_cnt` and `skip_cnt` are all 0.
  - `out_instr` is `'{opc:ZERO, default:0}`.
- IDLE, `start`=1:
  - Load `read_pointer` from `start_ptr` and `remaining` from min(`count`, DEPTH).
  - Clear `issued_cnt` and `skip_cnt`.
  - If `remaining` is 0, go to DRAIN. Otherwise go to RUN.
- RUN:
  - `can_load` = !`out_valid` || `out_ready`.
  - If `can_load` and `valid`=1: load `out_instr` from `instruction_word`, set `out_valid`=1 and increment `issued_cnt`.
  - If `can_load` and `valid`=0: increment `skip_cnt`; `out_valid` becomes 0 if the held entry was accepted this cycle.
  - Whenever `can_load` is true, increment `read_pointer` modulo DEPTH (31 wraps to 0) and decrement `remaining`.
  - When `remaining` reaches 0, go to DRAIN.
  - If `can_load` is false, hold `read_pointer`, `remaining`, `out_instr` and `out_valid`.
- DRAIN:
  - If `out_valid`=0, or `out_valid` && `out_ready`: clear `out_valid`, pulse `done` on the next cycle and go to IDLE.
- `abort`, in any state:
  - Go to IDLE next cycle and clear `out_valid`.
  - No `done` pulse.
  - The counters keep their current values.
  - `abort` has priority over `start` and over load decisions.
- `start` while `busy` is ignored.
- Simultaneous `done` and `start`: `start` is sampled in the cycle after `done`, once the state is IDLE.
- `out_instr` must stay stable while `out_valid` && !`out_ready`.
- Both counters saturate at 2^CNT_W-1. With CNT_W=6 this cannot be reached when `count` ≤ DEPTH.
- Reset asserted mid-run immediately forces all reset values; no partial issue survives.

## Timing
- `start` at cycle N: `busy`=1 and `read_pointer`=`start_ptr` at N+1; first `out_valid`=1 at N+2 if the entry is valid.
- Throughput with `out_ready` held high: one entry per cycle, including skipped entries.
- `done` pulses two cycles after the last entry is fetched, when that entry is accepted immediately or was skipped.
- `busy` falls in the same cycle that `done` rises.
- `count`=0: `done` pulses at N+2 with no issue.
- Back-pressure: the same `read_pointer` is held for as many cycles as `out_ready`=0 with `out_valid`=1.

## Test plan
- **Basic run:** entries 0..3 loaded valid, `start_ptr`=0, `count`=4, `out_ready`=1 → four issues in order at N+2..N+5; `issued_cnt`=4, `skip_cnt`=0; `done` at N+6.
- **Skip:** entries 2 and 4 invalid, `start_ptr`=1, `count`=5 → issues entries 1, 3 and 5 only; `skip_cnt`=2, `issued_cnt`=3.
- **Wrap:** `start_ptr`=30, `count`=4 → `read_pointer` sequence is 30, 31, 0, 1; all four issued.
- **Back-pressure:** `out_ready` low for 3 cycles on the second issue → `out_instr` stable for those cycles; no entry lost or duplicated; total latency extended by exactly 3.
- **Abort/reset:**
  - `abort` mid-run → IDLE next cycle, `out_valid`=0, no `done`.
  - `reset_n` pulled low mid-run → all outputs at reset values asynchronously.
- **Edge counts:**
  - `count`=0 → `done` at N+2, nothing issued.
  - `count`=40 → exactly 32 entries walked.
  - `start` pulsed while `busy` → ignored.
